// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Bridges a CPU MEM-stage load/store request onto a single-port data RAM with
// a registered output (2-cycle read latency: address on the ram_en edge, data
// moves into the RAM output register on the ram_re edge).
//
// Loads:           IDLE -> RD_EN -> RD_REG -> RD_CAP -> IDLE
// Word stores:     IDLE -> WR -> IDLE
// Sub-word stores: IDLE -> RD_EN -> RD_REG -> RD_CAP -> WR -> IDLE
//                  (read-modify-write of the containing word)
// Errored requests never leave IDLE; the error response is presented in the
// cycle after accept.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   req_*           request channel (valid/ready handshake, accepted in IDLE)
//   rsp_valid       one-cycle completion pulse, rsp_err / rsp_rdata qualified
//   busy            stall to the pipeline (NOT req_ready)
//   ram_*           RAM control; decoded only from state and latched request
//   ram_dout        RAM registered read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int RAM_DEPTH  = 15,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [31:0]           rsp_rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic                  ram_re,
   input  logic [31:0]           ram_dout
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_EN  = 3'd1,
      RD_REG = 3'd2,
      RD_CAP = 3'd3,
      WR     = 3'd4
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   // One extra bit so the depth compare cannot wrap when RAM_DEPTH == 2**ADDR_WIDTH.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);

   state_t                  state_q,     state_d;
   logic                    write_q,     write_d;
   logic [1:0]              size_q,      size_d;
   logic                    signed_q,    signed_d;
   logic [ADDR_WIDTH+1:0]   addr_q,      addr_d;
   // Holds store data on accept; replaced by the merged word at RD_CAP for
   // sub-word stores so WR always writes wdata_q.
   logic [31:0]             wdata_q,     wdata_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_err_q,   rsp_err_d;
   logic [31:0]             rsp_rdata_q, rsp_rdata_d;

   logic [ADDR_WIDTH-1:0]   req_idx;
   logic                    req_err;
   logic [7:0]              load_byte;
   logic [15:0]             load_half;
   logic [31:0]             load_data;
   logic [3:0]              lane_mask;
   logic [31:0]             merge_word;

   // -------------------------------------------------------------------------
   // Request legality, evaluated on the raw request while in IDLE
   // -------------------------------------------------------------------------
   assign req_idx = req_addr[ADDR_WIDTH+1:2];

   always_comb begin
      req_err = 1'b0;
      if (req_size == SIZE_ILL)
         req_err = 1'b1;
      if ((req_size == SIZE_HALF) && req_addr[0])
         req_err = 1'b1;
      if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
         req_err = 1'b1;
      if ({1'b0, req_idx} >= DEPTH_LIM)
         req_err = 1'b1;
   end

   // -------------------------------------------------------------------------
   // Little-endian load extraction from the RAM output register
   // -------------------------------------------------------------------------
   always_comb begin
      load_byte = ram_dout[7:0];
      case (addr_q[1:0])
         2'd0: load_byte = ram_dout[7:0];
         2'd1: load_byte = ram_dout[15:8];
         2'd2: load_byte = ram_dout[23:16];
         2'd3: load_byte = ram_dout[31:24];
         default: load_byte = ram_dout[7:0];
      endcase
      load_half = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];

      case (size_q)
         SIZE_BYTE: load_data = {{24{signed_q & load_byte[7]}}, load_byte};
         SIZE_HALF: load_data = {{16{signed_q & load_half[15]}}, load_half};
         default:   load_data = ram_dout;
      endcase
   end

   // -------------------------------------------------------------------------
   // Read-modify-write merge: replace only the addressed lane(s)
   // -------------------------------------------------------------------------
   always_comb begin
      lane_mask = 4'b0000;
      case (size_q)
         SIZE_BYTE: lane_mask[addr_q[1:0]] = 1'b1;
         SIZE_HALF: lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
         default:   lane_mask = 4'b1111;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         if (gi % 2 == 1) begin : g_odd
            // Odd lanes take the upper store byte for half stores.
            assign merge_word[8*gi +: 8] = lane_mask[gi]
                                         ? (size_q[0] ? wdata_q[15:8] : wdata_q[7:0])
                                         : ram_dout[8*gi +: 8];
         end else begin : g_even
            assign merge_word[8*gi +: 8] = lane_mask[gi] ? wdata_q[7:0]
                                                         : ram_dout[8*gi +: 8];
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      size_d      = size_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (req_write && (req_size == SIZE_WORD)) begin
                  state_d = WR;
               end else begin
                  state_d = RD_EN;
               end
            end
         end
         RD_EN:  state_d = RD_REG;
         RD_REG: state_d = RD_CAP;
         RD_CAP: begin
            if (write_q) begin
               wdata_d = merge_word;
               state_d = WR;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_data;
               state_d     = IDLE;
            end
         end
         WR: begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: RAM controls decode only from state and latched request
   // -------------------------------------------------------------------------
   always_comb begin
      req_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      ram_en    = (state_q == RD_EN) || (state_q == WR);
      ram_we    = (state_q == WR);
      ram_re    = (state_q == RD_REG);
      ram_addr  = (state_q != IDLE) ? addr_q[ADDR_WIDTH+1:2] : '0;
      ram_din   = (state_q == WR) ? wdata_q : '0;
      rsp_valid = rsp_valid_q;
      rsp_err   = rsp_err_q;
      rsp_rdata = rsp_rdata_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl with a behavioural 2-cycle-latency RAM.
// Every step prints one line; each comparison is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic [3:0]  ram_addr;
   logic [31:0] ram_din;
   logic        ram_en;
   logic        ram_we;
   logic        ram_re;
   logic [31:0] ram_dout;

   int checks = 0;
   int errors = 0;
   int en_edges = 0;

   // Behavioural RAM: read address captured on ram_en, output register on ram_re.
   logic [31:0] mem [0:15];
   logic [31:0] ram_rd1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         en_edges <= en_edges + 1;
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_rd1       <= mem[ram_addr];
      end
      if (ram_re) ram_dout <= ram_rd1;
   end

   mem_access_ctrl #(.RAM_DEPTH(15), .ADDR_WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_rdata  (rsp_rdata),
      .busy       (busy),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_re     (ram_re),
      .ram_dout   (ram_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [5:0] a, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   // Issue one request starting at posedge+1, measure edges to rsp_valid,
   // check the response and that the pulse lasts one cycle. Ends at posedge+1.
   task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [5:0] a, input logic [31:0] wd,
                         input int exp_n, input logic exp_err, input logic [31:0] exp_rd);
      int n;
      int en0;
      drive(w, sz, sg, a, wd);
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      en0 = en_edges;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = 32'hFFFF_FFFF;
      n = 1;
      while (!rsp_valid && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_n));
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, " rdata"}, rsp_rdata, exp_rd);
      if (exp_err) chk({tag, " no ram_en"}, 32'(en_edges - en0), 32'd0);
      $display("step %s: n=%0d err=%0b rdata=%h", tag, n, rsp_err, rsp_rdata);
      @(posedge clk); #1;
      chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      ram_rd1    = 32'h0;
      ram_dout   = 32'h0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 6'h00;
      req_wdata  = 32'h0;
      #1 reset = 1'b0;
      #2;
      chk("rst ready", 32'(req_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'd0);
      chk("rst ram_en", 32'(ram_en), 32'd0);
      chk("rst ram_we", 32'(ram_we), 32'd0);
      chk("rst ram_re", 32'(ram_re), 32'd0);
      chk("rst ram_addr", 32'(ram_addr), 32'd0);
      chk("rst ram_din", ram_din, 32'd0);
      $display("step reset: ready=%0b busy=%0b", req_ready, busy);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #1;

      // Word store / word load round trip
      do_req("st_w 08", 1'b1, 2'b10, 1'b0, 6'h08, 32'hDEADBEEF, 2, 1'b0, 32'h0);
      chk("mem[2] after st_w", mem[2], 32'hDEADBEEF);

      // Load with per-state RAM control checks
      drive(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("ld RD_EN en", 32'(ram_en), 32'd1);
      chk("ld RD_EN we", 32'(ram_we), 32'd0);
      chk("ld RD_EN addr", 32'(ram_addr), 32'd2);
      chk("ld busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("ld RD_REG re", 32'(ram_re), 32'd1);
      chk("ld RD_REG en", 32'(ram_en), 32'd0);
      @(posedge clk); #1;
      chk("ld RD_CAP dout", ram_dout, 32'hDEADBEEF);
      chk("ld RD_CAP valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("ld_w 08 valid n4", 32'(rsp_valid), 32'd1);
      chk("ld_w 08 rdata", rsp_rdata, 32'hDEADBEEF);
      chk("ld_w 08 err", 32'(rsp_err), 32'd0);
      $display("step ld_w 08: rdata=%h", rsp_rdata);
      @(posedge clk); #1;

      // Sub-word stores and extending loads
      do_req("st_b 09", 1'b1, 2'b00, 1'b0, 6'h09, 32'h000000AA, 5, 1'b0, 32'h0);
      chk("mem[2] after st_b", mem[2], 32'hDEADAAEF);
      do_req("ld_w 08b", 1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 4, 1'b0, 32'hDEADAAEF);
      do_req("ld_bs 09", 1'b0, 2'b00, 1'b1, 6'h09, 32'h0, 4, 1'b0, 32'hFFFFFFAA);
      do_req("ld_bu 09", 1'b0, 2'b00, 1'b0, 6'h09, 32'h0, 4, 1'b0, 32'h000000AA);
      do_req("ld_hs 0A", 1'b0, 2'b01, 1'b1, 6'h0A, 32'h0, 4, 1'b0, 32'hFFFFDEAD);
      do_req("ld_hu 08", 1'b0, 2'b01, 1'b0, 6'h08, 32'h0, 4, 1'b0, 32'h0000AAEF);
      do_req("ld_bs 08", 1'b0, 2'b00, 1'b1, 6'h08, 32'h0, 4, 1'b0, 32'hFFFFFFEF);
      do_req("st_h 0A", 1'b1, 2'b01, 1'b0, 6'h0A, 32'hABCD1234, 5, 1'b0, 32'h0);
      do_req("ld_ws 08", 1'b0, 2'b10, 1'b1, 6'h08, 32'h0, 4, 1'b0, 32'h1234AAEF);
      do_req("st_b 0B", 1'b1, 2'b00, 1'b0, 6'h0B, 32'h00000099, 5, 1'b0, 32'h0);
      chk("mem[2] after st_b 0B", mem[2], 32'h9934AAEF);

      // Error cases
      do_req("err ld_w 06", 1'b0, 2'b10, 1'b0, 6'h06, 32'h0, 1, 1'b1, 32'h0);
      do_req("err ld_h 03", 1'b0, 2'b01, 1'b0, 6'h03, 32'h0, 1, 1'b1, 32'h0);
      do_req("err size11", 1'b0, 2'b11, 1'b0, 6'h00, 32'h0, 1, 1'b1, 32'h0);
      do_req("err ld_w 3C", 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 1, 1'b1, 32'h0);
      do_req("err st_b 3D", 1'b1, 2'b00, 1'b0, 6'h3D, 32'h55, 1, 1'b1, 32'h0);
      do_req("ok ld_w 38", 1'b0, 2'b10, 1'b0, 6'h38, 32'h0, 4, 1'b0, 32'h0);
      chk("mem[2] after errors", mem[2], 32'h9934AAEF);

      // Back-to-back: load held valid while the store response is presented
      drive(1'b1, 2'b10, 1'b0, 6'h10, 32'hCAFEF00D);
      @(posedge clk); #1;
      chk("b2b WR ready", 32'(req_ready), 32'd0);
      drive(1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
      @(posedge clk); #1;
      chk("b2b st rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b st ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b ld accepted", 32'(req_ready), 32'd0);
      chk("b2b st pulse", 32'(rsp_valid), 32'd0);
      n = 1;
      while (!rsp_valid && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b ld latency", 32'(n), 32'd4);
      chk("b2b ld rdata", rsp_rdata, 32'hCAFEF00D);
      $display("step b2b: n=%0d rdata=%h", n, rsp_rdata);
      @(posedge clk); #1;

      // Reset during WR of a byte store
      do_req("st_w 0C", 1'b1, 2'b10, 1'b0, 6'h0C, 32'h11223344, 2, 1'b0, 32'h0);
      drive(1'b1, 2'b00, 1'b0, 6'h0D, 32'h00000055);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("rmw WR we", 32'(ram_we), 32'd1);
      chk("rmw WR addr", 32'(ram_addr), 32'd3);
      chk("rmw WR din", ram_din, 32'h11225544);
      #2 reset = 1'b0;
      #1;
      chk("rstWR we", 32'(ram_we), 32'd0);
      chk("rstWR en", 32'(ram_en), 32'd0);
      chk("rstWR ready", 32'(req_ready), 32'd1);
      chk("rstWR busy", 32'(busy), 32'd0);
      chk("rstWR rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("rstWR no rsp", 32'(seen), 32'd0);
      chk("rstWR ready after", 32'(req_ready), 32'd1);
      chk("rstWR mem[3]", mem[3], 32'h11223344);
      $display("step reset-in-WR: mem[3]=%h seen=%0d", mem[3], seen);
      do_req("ld_w 0C", 1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, 4, 1'b0, 32'h11223344);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
